// File: rtl/test_mem_driver.sv
// test_mem_driver: initiator-side DMA test engine for the test memory device.
// Write mode streams an address-derived incrementing/decrementing pattern into
// the device's ping-pong write FIFO. Read mode drains the read FIFO and checks
// the same pattern.
// Optional feature macro: TEST_MEM_DRIVER_TIMEOUT_EN. When it is defined, a
// stall watchdog behaves as abort after TIMEOUT_CYCLES idle cycles.
module test_mem_driver #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dir,
  input  logic [63:0] start_addr,
  input  logic [23:0] xfer_count,
  input  logic        addr_dec,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] error_count,
  output logic [23:0] words_xferred,
  output logic        write_enable,
  output logic [63:0] write_addr,
  output logic        write_addr_inc,
  output logic        write_addr_dec,
  output logic [23:0] write_count,
  output logic        write_flush,
  input  logic        write_finished,
  input  logic [1:0]  write_ready,
  output logic [1:0]  write_activate,
  input  logic [23:0] write_size,
  output logic        write_strobe,
  output logic [31:0] write_data,
  output logic        read_enable,
  output logic [63:0] read_addr,
  output logic        read_addr_inc,
  output logic        read_addr_dec,
  output logic [23:0] read_count,
  output logic        read_flush,
  input  logic        read_busy,
  input  logic        read_error,
  input  logic        read_ready,
  output logic        read_activate,
  input  logic [23:0] read_size,
  input  logic [31:0] read_data,
  output logic        read_strobe
);

  typedef enum logic [3:0] {
    IDLE, W_ARM, W_GRAB, W_FILL, W_REL, W_FIN,
    R_ARM, R_GRAB, R_DRAIN, R_REL, DONE
  } state_t;

  state_t                   state;
  logic                     dir_r;
  logic                     dec_r;
  logic [ADDRESS_WIDTH-1:0] expected;
  logic [23:0]              remaining;
  logic [23:0]              chunk_left;
  logic                     timeout;
  logic                     rd_state;

  // read_busy carries no behaviour here; it is accepted for interface completeness
  logic unused_read_busy;
  assign unused_read_busy = read_busy;

  assign busy     = (state != IDLE) && (state != DONE);
  assign done     = (state == DONE);
  assign rd_state = (state == R_ARM) || (state == R_GRAB) ||
                    (state == R_DRAIN) || (state == R_REL);

  // next pattern value, wrapping modulo 2**ADDRESS_WIDTH
  function automatic logic [ADDRESS_WIDTH-1:0] step_e(
    input logic [ADDRESS_WIDTH-1:0] e, input logic dec);
    return dec ? e - ADDRESS_WIDTH'(1) : e + ADDRESS_WIDTH'(1);
  endfunction

  function automatic logic [23:0] min24(input logic [23:0] a, input logic [23:0] b);
    return (a < b) ? a : b;
  endfunction

`ifdef TEST_MEM_DRIVER_TIMEOUT_EN
  logic [15:0] stall_cnt;
  state_t      last_state;
  logic        waiting;

  assign waiting = (state == W_GRAB) || (state == W_FIN) ||
                   (state == R_GRAB) || (state == R_DRAIN);
  assign timeout = waiting && (stall_cnt == 16'(TIMEOUT_CYCLES));

  // watchdog: cleared by any strobe or state change, counts only while waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= 16'd0;
      last_state <= IDLE;
    end else begin
      last_state <= state;
      if (!waiting || state != last_state || write_strobe || read_strobe)
        stall_cnt <= 16'd0;
      else if (stall_cnt != 16'(TIMEOUT_CYCLES))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  // no watchdog: the comparison is constant false and only keeps the parameter referenced
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // main sequencer: latches the request, runs the FIFO handshakes, checks read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      dir_r          <= 1'b0;
      dec_r          <= 1'b0;
      expected       <= '0;
      remaining      <= 24'd0;
      chunk_left     <= 24'd0;
      error          <= 1'b0;
      error_count    <= 16'd0;
      words_xferred  <= 24'd0;
      write_enable   <= 1'b0;
      write_addr     <= 64'd0;
      write_addr_inc <= 1'b0;
      write_addr_dec <= 1'b0;
      write_count    <= 24'd0;
      write_flush    <= 1'b0;
      write_activate <= 2'b00;
      write_strobe   <= 1'b0;
      write_data     <= 32'd0;
      read_enable    <= 1'b0;
      read_addr      <= 64'd0;
      read_addr_inc  <= 1'b0;
      read_addr_dec  <= 1'b0;
      read_count     <= 24'd0;
      read_flush     <= 1'b0;
      read_activate  <= 1'b0;
      read_strobe    <= 1'b0;
    end else begin
      write_strobe <= 1'b0;
      read_strobe  <= 1'b0;
      write_flush  <= 1'b0;
      read_flush   <= 1'b0;

      // a visible read strobe pops the word on read_data, so check it now
      if (read_strobe) begin
        if (read_data != 32'(expected)) begin
          error <= 1'b1;
          if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
        end
        expected <= step_e(expected, dec_r);
      end

      if (rd_state && read_error) error <= 1'b1;

      if (busy && (abort || timeout)) begin
        // abort beats any strobe or grab scheduled for this cycle
        write_enable   <= 1'b0;
        write_activate <= 2'b00;
        read_enable    <= 1'b0;
        read_activate  <= 1'b0;
        if (dir_r) read_flush  <= 1'b1;
        else       write_flush <= 1'b1;
        error <= 1'b1;
        if (timeout) error_count <= 16'hFFFF;
        state <= DONE;
      end else begin
        case (state)
          IDLE: if (start) begin
            dir_r          <= dir;
            dec_r          <= addr_dec;
            expected       <= start_addr[ADDRESS_WIDTH-1:0];
            remaining      <= xfer_count;
            words_xferred  <= 24'd0;
            error          <= 1'b0;
            error_count    <= 16'd0;
            write_addr     <= start_addr;
            read_addr      <= start_addr;
            write_count    <= xfer_count;
            read_count     <= xfer_count;
            write_addr_inc <= !addr_dec;
            write_addr_dec <= addr_dec;
            read_addr_inc  <= !addr_dec;
            read_addr_dec  <= addr_dec;
            if (xfer_count == 24'd0) begin
              state <= DONE;
            end else if (dir) begin
              read_enable <= 1'b1;
              state       <= R_ARM;
            end else begin
              write_enable <= 1'b1;
              state        <= W_ARM;
            end
          end
          W_ARM: state <= W_GRAB;
          W_GRAB: if (write_activate == 2'b00 && write_ready != 2'b00) begin
            write_activate <= write_ready[0] ? 2'b01 : 2'b10;
            chunk_left     <= min24(write_size, remaining);
            state          <= W_FILL;
          end
          W_FILL: begin
            if (chunk_left != 24'd0) begin
              write_strobe  <= 1'b1;
              write_data    <= 32'(expected);
              expected      <= step_e(expected, dec_r);
              chunk_left    <= chunk_left - 24'd1;
              remaining     <= remaining - 24'd1;
              words_xferred <= words_xferred + 24'd1;
              if (chunk_left == 24'd1) state <= W_REL;
            end else begin
              state <= W_REL;
            end
          end
          W_REL: begin
            write_activate <= 2'b00;
            state          <= (remaining != 24'd0) ? W_GRAB : W_FIN;
          end
          W_FIN: if (write_finished) begin
            write_enable <= 1'b0;
            state        <= DONE;
          end
          R_ARM: state <= R_GRAB;
          R_GRAB: if (read_ready && !read_activate) begin
            read_activate <= 1'b1;
            chunk_left    <= min24(read_size, remaining);
            state         <= R_DRAIN;
          end
          R_DRAIN: begin
            if (chunk_left != 24'd0) begin
              read_strobe   <= 1'b1;
              chunk_left    <= chunk_left - 24'd1;
              remaining     <= remaining - 24'd1;
              words_xferred <= words_xferred + 24'd1;
              if (chunk_left == 24'd1) state <= R_REL;
            end else begin
              state <= R_REL;
            end
          end
          R_REL: begin
            read_activate <= 1'b0;
            if (remaining != 24'd0) begin
              state <= R_GRAB;
            end else begin
              read_enable <= 1'b0;
              state       <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_test_mem_driver.sv
// Directed bench for test_mem_driver with a small behavioural model of the
// test memory device (ping-pong write FIFO sink, read FIFO source).
module tb_test_mem_driver;

  logic        clk = 1'b0;
  logic        rst, start, dir, addr_dec, abort;
  logic [63:0] start_addr;
  logic [23:0] xfer_count;
  logic        busy, done, error;
  logic [15:0] error_count;
  logic [23:0] words_xferred;
  logic        write_enable, write_addr_inc, write_addr_dec, write_flush;
  logic [63:0] write_addr, read_addr;
  logic [23:0] write_count, read_count;
  logic        write_finished;
  logic [1:0]  write_ready, write_activate;
  logic [23:0] write_size, read_size;
  logic        write_strobe;
  logic [31:0] write_data, read_data;
  logic        read_enable, read_addr_inc, read_addr_dec, read_flush;
  logic        read_busy, read_error, read_ready, read_activate, read_strobe;

  int vectors = 0;
  int miscompares = 0;

  // device model state
  logic [31:0] wq[$];
  int          wchunks[$];
  int          rchunks[$];
  int          wbase = 0, rbase = 0, wcbase = 0, rcbase = 0;
  int          rcount = 0, wgrabs = 0, rgrabs = 0, wrun = 0, rrun = 0;
  int          wlate = 0, rlate = 0;
  logic [1:0]  wact_q = 2'b00, wact_last = 2'b00;
  logic        ract_q = 1'b0, ws_q = 1'b0, rs_q = 1'b0;
  logic        hold_wf = 1'b0, corrupt = 1'b0;

  always #5 clk = ~clk;

  test_mem_driver dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .start_addr(start_addr),
    .xfer_count(xfer_count), .addr_dec(addr_dec), .abort(abort),
    .busy(busy), .done(done), .error(error), .error_count(error_count),
    .words_xferred(words_xferred),
    .write_enable(write_enable), .write_addr(write_addr),
    .write_addr_inc(write_addr_inc), .write_addr_dec(write_addr_dec),
    .write_count(write_count), .write_flush(write_flush),
    .write_finished(write_finished), .write_ready(write_ready),
    .write_activate(write_activate), .write_size(write_size),
    .write_strobe(write_strobe), .write_data(write_data),
    .read_enable(read_enable), .read_addr(read_addr),
    .read_addr_inc(read_addr_inc), .read_addr_dec(read_addr_dec),
    .read_count(read_count), .read_flush(read_flush),
    .read_busy(read_busy), .read_error(read_error), .read_ready(read_ready),
    .read_activate(read_activate), .read_size(read_size),
    .read_data(read_data), .read_strobe(read_strobe)
  );

  // device memory holds mem[a] = a; word 5 of a transfer can be corrupted on bit 3
  assign read_data = 32'(rcount - rbase) |
                     ((corrupt && (rcount - rbase) == 5) ? 32'h8 : 32'h0);

  // write FIFO sink: capture words, record per-grab chunk sizes, raise finished
  always @(posedge clk) begin
    wact_q <= write_activate;
    ws_q   <= write_strobe;
    if (write_strobe) wq.push_back(write_data);
    if (write_activate != 2'b00 && wact_q == 2'b00) begin
      wrun      <= 0;
      wgrabs    <= wgrabs + 1;
      wact_last <= write_activate;
    end else if (write_strobe) wrun <= wrun + 1;
    if (write_activate == 2'b00 && wact_q != 2'b00) begin
      wchunks.push_back(wrun);
      if (wrun != 0 && !ws_q) wlate <= wlate + 1;
    end
    write_finished <= !hold_wf && write_enable && write_count != 24'd0 &&
                      (wq.size() - wbase >= int'(write_count));
  end

  // read FIFO source: pop on strobe, record per-grab chunk sizes
  always @(posedge clk) begin
    ract_q <= read_activate;
    rs_q   <= read_strobe;
    if (read_strobe) rcount <= rcount + 1;
    if (read_activate && !ract_q) begin
      rrun   <= 0;
      rgrabs <= rgrabs + 1;
    end else if (read_strobe) rrun <= rrun + 1;
    if (!read_activate && ract_q) begin
      rchunks.push_back(rrun);
      if (rrun != 0 && !rs_q) rlate <= rlate + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic d, input logic [63:0] a, input logic [23:0] n,
                             input logic dec);
    dir = d; start_addr = a; xfer_count = n; addr_dec = dec;
    wbase = wq.size(); rbase = rcount; wcbase = wchunks.size(); rcbase = rchunks.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " busy@done"}, busy, 1'b0);
  endtask

  initial begin
    int g0;
    int n;
    rst = 1'b1; start = 1'b0; dir = 1'b0; addr_dec = 1'b0; abort = 1'b0;
    start_addr = 64'd0; xfer_count = 24'd0;
    write_ready = 2'b01; write_size = 24'd8; read_ready = 1'b1; read_size = 24'd8;
    read_busy = 1'b0; read_error = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset status", {busy, done, error, write_enable, read_enable, write_activate,
        read_activate, write_strobe, read_strobe, write_flush, read_flush}, 0);
    chk("reset counters", {error_count, words_xferred}, 0);
    chk("reset data", {write_data, write_count}, 0);
    rst = 1'b0;
    @(negedge clk);

    // write 16 words from 0x10 through an 8-deep FIFO; a second start is ignored
    g0 = wgrabs;
    pulse_start(1'b0, 64'h10, 24'd16, 1'b0);
    chk("w1 busy", busy, 1'b1);
    chk("w1 enable", write_enable, 1'b1);
    repeat (3) @(negedge clk);
    dir = 1'b1; start_addr = 64'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("w1", 200);
    chk("w1 words", words_xferred, 24'd16);
    chk("w1 error", error, 1'b0);
    chk("w1 addr held", write_addr, 64'h10);
    chk("w1 inc/dec", {write_addr_inc, write_addr_dec, write_count}, {2'b10, 24'd16});
    chk("w1 read idle", read_enable, 1'b0);
    chk("w1 grabs", wgrabs - g0, 2);
    chk("w1 chunks", {wchunks[wcbase], wchunks[wcbase+1]}, {32'd8, 32'd8});
    chk("w1 count", wq.size() - wbase, 16);
    for (int i = 0; i < 16; i++) chk("w1 data", wq[wbase+i], 32'h10 + i);
    chk("w1 act bank", wact_last, 2'b01);
    @(negedge clk);
    chk("w1 done pulse", done, 1'b0);

    // wrap upward, FIFO depth 5 through bank 1: chunks 5 then 3
    write_ready = 2'b10; write_size = 24'd5;
    pulse_start(1'b0, 64'hFC, 24'd8, 1'b0);
    wait_done("wrap", 200);
    chk("wrap chunks", {wchunks[wcbase], wchunks[wcbase+1]}, {32'd5, 32'd3});
    chk("wrap bank", wact_last, 2'b10);
    for (int i = 0; i < 8; i++) chk("wrap data", wq[wbase+i], 32'((8'hFC + i) & 8'hFF));
    @(negedge clk);

    // wrap downward from 0x01
    write_ready = 2'b01; write_size = 24'd8;
    pulse_start(1'b0, 64'h01, 24'd4, 1'b1);
    wait_done("dec", 200);
    chk("dec addr ctl", {write_addr_inc, write_addr_dec, read_addr_dec}, 3'b011);
    chk("dec data", {wq[wbase], wq[wbase+1], wq[wbase+2], wq[wbase+3]},
        {32'h01, 32'h00, 32'hFF, 32'hFE});
    @(negedge clk);

    // zero FIFO size: grabs release with no strobes until space appears
    write_size = 24'd0;
    g0 = wgrabs;
    pulse_start(1'b0, 64'h20, 24'd2, 1'b0);
    repeat (12) @(negedge clk);
    chk("size0 no strobes", wq.size() - wbase, 0);
    chk("size0 regrabs", (wgrabs - g0) >= 2, 1'b1);
    write_size = 24'd8;
    wait_done("size0", 200);
    chk("size0 data", {wq[wbase], wq[wbase+1]}, {32'h20, 32'h21});
    @(negedge clk);

    // zero count completes immediately
    pulse_start(1'b0, 64'h0, 24'd0, 1'b0);
    chk("zero done", {done, busy, write_enable}, 3'b100);
    @(negedge clk);
    chk("zero idle", done, 1'b0);

    // read 32 words of mem[a]=a through an 8-deep FIFO
    g0 = rgrabs;
    pulse_start(1'b1, 64'h0, 24'd32, 1'b0);
    chk("r1 enable", read_enable, 1'b1);
    wait_done("r1", 400);
    chk("r1 status", {error, error_count, words_xferred}, {1'b0, 16'd0, 24'd32});
    chk("r1 read_enable off", read_enable, 1'b0);
    @(negedge clk);
    chk("r1 grabs", rgrabs - g0, 4);
    for (int i = 0; i < 4; i++) chk("r1 chunk", rchunks[rcbase+i], 8);

    // read with word 5 corrupted
    corrupt = 1'b1;
    pulse_start(1'b1, 64'h0, 24'd8, 1'b0);
    wait_done("r2", 200);
    chk("r2 error", {error, error_count}, {1'b1, 16'd1});
    chk("r2 words", words_xferred, 24'd8);
    corrupt = 1'b0;
    @(negedge clk);

    // device read error sets error without counting
    pulse_start(1'b1, 64'h0, 24'd4, 1'b0);
    read_error = 1'b1;
    @(negedge clk);
    read_error = 1'b0;
    wait_done("rerr", 200);
    chk("rerr status", {error, error_count}, {1'b1, 16'd0});
    @(negedge clk);

    // abort on the fourth visible write strobe
    pulse_start(1'b0, 64'h40, 24'd16, 1'b0);
    n = 0;
    while ((wq.size() - wbase) < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort reached", (wq.size() - wbase) >= 3, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort lines", {write_activate, write_enable, write_strobe}, 0);
    chk("abort flush", {write_flush, read_flush, done}, 3'b101);
    chk("abort words", words_xferred, 24'd4);
    @(negedge clk);
    chk("abort after", {write_flush, done, error, busy}, 4'b0010);

    // synchronous reset in the middle of a read drain
    pulse_start(1'b1, 64'h0, 24'd32, 1'b0);
    n = 0;
    while ((rcount - rbase) < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst reached", (rcount - rbase) >= 5, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst lines", {busy, done, error, read_enable, read_activate, read_strobe,
        read_flush, write_enable}, 0);
    chk("rst regs", {words_xferred, read_addr, read_count}, 0);
    rst = 1'b0;
    @(negedge clk);

`ifdef TEST_MEM_DRIVER_TIMEOUT_EN
    hold_wf = 1'b1;
    pulse_start(1'b0, 64'h0, 24'd4, 1'b0);
    wait_done("tmo", 4500);
    chk("tmo status", {error, error_count, write_flush}, {1'b1, 16'hFFFF, 1'b1});
    hold_wf = 1'b0;
    @(negedge clk);
`endif

    chk("write release timing", wlate, 0);
    chk("read release timing", rlate, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
